// File: rtl/timer_ctrl.sv
// Start/pause/abort up-counter with one-cycle DONE pulse and registered status outputs.
// Optional periodic reload from DONE is enabled by defining AUTO_RELOAD_EN.
module timer_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             busy_q;
  logic             done_q;

`ifndef AUTO_RELOAD_EN
  logic unused_periodic;
  assign unused_periodic = periodic;
`endif

  // Next state is resolved locally so busy/done can be registered in step with state.
  always_ff @(posedge clk) begin
    state_t           nxt;
    logic [WIDTH-1:0] cnt_nxt;
    nxt     = state_q;
    cnt_nxt = count_q;
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            nxt     = RUN;
            cnt_nxt = '0;
            limit_q <= limit;
          end
        end
        RUN: begin
          if (abort) begin
            nxt     = IDLE;
            cnt_nxt = '0;
          end else if (pause) begin
            nxt = HOLD;
          end else if (count_q == limit_q) begin
            nxt = DONE;
          end else begin
            cnt_nxt = count_q + 1'b1;
          end
        end
        HOLD: begin
          if (abort) begin
            nxt     = IDLE;
            cnt_nxt = '0;
          end else if (!pause) begin
            nxt = RUN;
          end
        end
        DONE: begin
`ifdef AUTO_RELOAD_EN
          if (periodic) begin
            nxt     = RUN;
            cnt_nxt = '0;
          end else begin
            nxt = IDLE;
          end
`else
          nxt = IDLE;
`endif
        end
        default: nxt = IDLE;
      endcase
      state_q <= nxt;
      count_q <= cnt_nxt;
      busy_q  <= (nxt == RUN) || (nxt == HOLD);
      done_q  <= (nxt == DONE);
    end
  end

  assign state = state_q;
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_timer_ctrl;
  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             pause;
  logic             abort;
  logic             periodic;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int n_checks = 0;
  int n_errors = 0;

  // model: 0 idle, 1 counting, 2 frozen, 3 finished
  int m_mode = 0;
  int m_cnt  = 0;
  int m_lim  = 0;

  timer_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .periodic(periodic), .limit(limit), .count(count), .busy(busy),
    .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_edge();
    bit reload;
`ifdef AUTO_RELOAD_EN
    reload = periodic;
`else
    reload = 1'b0;
`endif
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_lim = 0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_cnt = 0; m_lim = int'(limit); end
    end else if (m_mode == 3) begin
      if (reload) begin m_mode = 1; m_cnt = 0; end
      else m_mode = 0;
    end else if (abort) begin
      m_mode = 0; m_cnt = 0;
    end else if (m_mode == 2) begin
      if (!pause) m_mode = 1;
    end else if (pause) begin
      m_mode = 2;
    end else if (m_cnt >= m_lim) begin
      m_mode = 3;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", state, m_mode);
    chk("count", count, m_cnt);
    chk("busy", busy, (m_mode == 1 || m_mode == 2));
    chk("done", done, (m_mode == 3));
  endtask

  task automatic idle_inputs();
    reset = 0; start = 0; pause = 0; abort = 0; periodic = 0;
  endtask

  task automatic run_to_count(input int target, input int budget);
    int k = 0;
    while (count != target[WIDTH-1:0] && k < budget) begin tick(); k++; end
    chk("reach_count", count, target);
  endtask

  initial begin
    int n;
    int last;
    int gaps;
    idle_inputs();
    limit = '0;

    // reset for two cycles with random other inputs
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      {start, pause, abort, periodic} = 4'($urandom);
      limit = WIDTH'($urandom);
      tick();
    end
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    idle_inputs();
    tick();

    // limit 5: done six edges after the start edge
    limit = 5; start = 1; tick(); start = 0;
    limit = 12;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk("l5_done_edge", n, 5 + 1);
    chk("l5_count", count, 5);
    tick();
    chk("l5_idle", state, 0);
    chk("l5_hold5", count, 5);
    chk("l5_one_pulse", done, 0);

    // limit 9 with four paused cycles at count 3
    limit = 9; start = 1; tick(); start = 0;
    run_to_count(3, 20);
    pause = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p_state", state, 2);
      chk("p_count", count, 3);
    end
    pause = 0;
    tick();
    chk("p_resume_cnt", count, 3);
    tick();
    chk("p_second_edge", count, 4);
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk("p_done_gap", n, (9 - 4) + 1);
    tick();

    // abort at count 7
    limit = 15; start = 1; tick(); start = 0;
    run_to_count(7, 30);
    abort = 1; tick(); abort = 0;
    chk("ab_state", state, 0);
    chk("ab_count", count, 0);
    for (int i = 0; i < 20; i++) begin tick(); chk("ab_nodone", done, 0); end

    // limit 0
    limit = 0; start = 1; tick(); start = 0;
    chk("l0_count0", count, 0);
    tick();
    chk("l0_done", done, 1);
    chk("l0_count", count, 0);
    tick();
    chk("l0_idle_count", count, 0);

    // reset mid-run: no done, resumes on next start
    limit = 6; start = 1; tick(); start = 0;
    tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("mr_state", state, 0);
    for (int i = 0; i < 10; i++) begin tick(); chk("mr_nodone", done, 0); end
    limit = 1; start = 1; tick(); start = 0;
    tick(); tick();
    chk("mr_resume_done", done, 1);
    tick();

    // periodic with limit 2
    limit = 2; periodic = 1; start = 1; tick(); start = 0;
    n = 0; last = -1; gaps = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done) begin
        if (last >= 0) begin
`ifdef AUTO_RELOAD_EN
          chk("per_period", i - last, 4);
`else
          chk("per_extra_done", 1, 0);
`endif
          gaps++;
        end
        last = i;
        n++;
      end
    end
`ifdef AUTO_RELOAD_EN
    chk("per_pulses", n, 6);
`else
    chk("per_single", n, 1);
    chk("per_idle", state, 0);
`endif
    periodic = 0;
    tick(); tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 3) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      abort    = ($urandom_range(0, 24) == 0);
      periodic = $urandom_range(0, 1) == 1;
      limit    = WIDTH'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, width of the count and the limit.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  run request; sampled only in IDLE.
REQ-005 Port: pause  input  1  level; while high, holds the count in RUN/HOLD.
REQ-006 Port: abort  input  1  cancels an active run.
REQ-007 Port: periodic  input  1  reload request; used only when AUTO_RELOAD_EN is defined.
REQ-008 Port: limit  input  WIDTH  terminal count; latched into limit_q on start acceptance.
REQ-009 Port: count  output  WIDTH  current up-count value.
REQ-010 Port: busy  output  1  high in RUN or HOLD.
REQ-011 Port: done  output  1  high exactly when state is DONE.
REQ-012 Port: state  output  2  state encoding: IDLE=0, RUN=1, HOLD=2, DONE=3.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, HOLD, DONE.
REQ-014 IDLE transitions:
- start=1: latch limit_q<=limit, set count<=0, go to RUN.
- start=0: stay in IDLE with count held.
REQ-015 RUN priority order (highest first):
- abort: go to IDLE, count<=0.
- pause: go to HOLD, count held.
- count==limit_q: go to DONE, count held.
- otherwise: count<=count+1.
REQ-016 HOLD transitions:
- abort: go to IDLE, count<=0.
- pause=0: go to RUN.
- otherwise: stay in HOLD, count held.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE with count held at limit_q (subject to REQ-027).
REQ-018 start SHALL be ignored outside IDLE; abort SHALL be ignored in IDLE and DONE.
REQ-019 Latency: with start accepted at edge N and limit L, the block SHALL reach DONE at edge N+L+1 and done SHALL be high for the following cycle only.
REQ-020 limit=0 SHALL give DONE at edge N+1 with count=0.
REQ-021 limit=2^WIDTH-1 SHALL terminate at that value; count SHALL never wrap.
REQ-022 Changes on the limit input during a run SHALL have no effect; only limit_q is used.
REQ-023 All outputs SHALL be registered or decoded from registered state only; no combinational path from any input to any output.

Reset
REQ-024 reset=1 at a rising edge SHALL force state=IDLE, count=0, limit_q=0, busy=0, done=0, overriding every other input.
REQ-025 reset asserted mid-run SHALL produce no done pulse; the block SHALL resume from IDLE on the first start after reset is released.

Configuration
REQ-026 Macro AUTO_RELOAD_EN SHALL select periodic reload.
REQ-027 AUTO_RELOAD_EN defined: in DONE with periodic=1, the block SHALL go to RUN with count<=0 and limit_q kept, giving period L+2 cycles; periodic=0 gives IDLE.
REQ-028 AUTO_RELOAD_EN undefined: the periodic input SHALL be ignored and DONE SHALL always go to IDLE.

Verification (WIDTH=4)
REQ-029 reset high for 2 cycles with random inputs -> state=0, count=0, busy=0, done=0.
REQ-030 limit=5, one-cycle start -> count 0,1,2,3,4,5; done high for exactly 1 cycle, 6 cycles after the start edge; then IDLE with count=5.
REQ-031 limit=9, pause high for 4 cycles at count=3 -> state=2, count held at 3; after pause drops, count=4 on the second edge; done after the 4 held cycles are added.
REQ-032 limit=15, abort at count=7 -> next cycle state=0, count=0; no done.
REQ-033 limit=0 -> done on the cycle after the start edge; count=0 throughout.
REQ-034 AUTO_RELOAD_EN defined, periodic=1, limit=2 -> done every 4 cycles indefinitely; macro undefined -> single done, then IDLE.
